// File: rtl/operand_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : operand_deserializer
// Purpose  : Reassembles a framed opcode plus NUM_OPS operands of DATA_W bits
//            from a narrow pin bus, delivered over one or more beats, and
//            presents the frame to the compute unit with valid/ready.
//            The pin side cannot be back-pressured, so framing problems and
//            frames dropped while holding are flagged as one-cycle pulses.
// Ports    : clock       - system clock
//            reset       - synchronous, active-high
//            io_in       - beat = {payload[PAY_W-1:0], sof, vld}
//            ops         - operand k at [k*DATA_W +: DATA_W]
//            op          - captured opcode
//            out_valid   - frame complete, ops/op stable
//            out_ready   - consumer accepts frame
//            err_sync    - pulse: beat outside a frame or resync header
//            err_overrun - pulse: header dropped while holding a frame
// Revision : 1.0 - initial release
// ============================================================================
module operand_deserializer #(
    parameter int PIN_W   = 12,
    parameter int DATA_W  = 10,
    parameter int NUM_OPS = 2,
    parameter int OP_W    = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [PIN_W-1:0]            io_in,
    output logic [NUM_OPS*DATA_W-1:0]   ops,
    output logic [OP_W-1:0]             op,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        err_sync,
    output logic                        err_overrun
);

    localparam int PAY_W = PIN_W - 2;
    localparam int BEATS = (DATA_W + PAY_W - 1) / PAY_W;
    localparam int BCW   = (BEATS > 1)   ? $clog2(BEATS)   : 1;
    localparam int OCW   = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t           state_q;
    logic [BCW-1:0]   beat_q;     // chunk index within the current operand
    logic [OCW-1:0]   opn_q;      // operand index within the current frame
    logic [OP_W-1:0]  op_q;
    logic             valid_q;
    logic             err_sync_q;
    logic             err_overrun_q;

    logic             w_vld;
    logic             w_sof;
    logic [PAY_W-1:0] w_pay;
    logic             w_hdr;
    logic             w_data;
    logic             w_last;
    logic             w_wr;

    assign w_vld  = io_in[0];
    assign w_sof  = io_in[1];
    assign w_pay  = io_in[PIN_W-1:2];
    assign w_hdr  = w_vld & w_sof;
    assign w_data = w_vld & ~w_sof;
    assign w_last = (opn_q == OCW'(NUM_OPS - 1)) && (beat_q == BCW'(BEATS - 1));
    assign w_wr   = (state_q == S_COLLECT) && w_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            beat_q        <= '0;
            opn_q         <= '0;
            op_q          <= '0;
            valid_q       <= 1'b0;
            err_sync_q    <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            err_sync_q    <= 1'b0;
            err_overrun_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_hdr) begin
                        op_q    <= w_pay[OP_W-1:0];
                        beat_q  <= '0;
                        opn_q   <= '0;
                        state_q <= S_COLLECT;
                    end else if (w_data) begin
                        err_sync_q <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (w_hdr) begin
                        // Resync: restart the frame; stale operand bits are
                        // overwritten as the new data beats arrive.
                        op_q       <= w_pay[OP_W-1:0];
                        beat_q     <= '0;
                        opn_q      <= '0;
                        err_sync_q <= 1'b1;
                    end else if (w_data) begin
                        if (w_last) begin
                            beat_q  <= '0;
                            opn_q   <= '0;
                            valid_q <= 1'b1;
                            state_q <= S_HOLD;
                        end else if (beat_q == BCW'(BEATS - 1)) begin
                            beat_q <= '0;
                            opn_q  <= opn_q + OCW'(1);
                        end else begin
                            beat_q <= beat_q + BCW'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        // A header arriving in the transfer cycle starts the
                        // next frame immediately without any error.
                        if (w_hdr) begin
                            op_q    <= w_pay[OP_W-1:0];
                            beat_q  <= '0;
                            opn_q   <= '0;
                            state_q <= S_COLLECT;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else if (w_hdr) begin
                        err_overrun_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Operand storage: each bit knows statically which chunk and payload bit
    // feed it, so payload bits beyond DATA_W in the last chunk are never kept.
    for (genvar k = 0; k < NUM_OPS; k++) begin : g_op
        for (genvar i = 0; i < DATA_W; i++) begin : g_bit
            localparam int CH  = i / PAY_W;
            localparam int OFS = i % PAY_W;
            logic bit_q;
            always_ff @(posedge clock) begin
                if (reset) begin
                    bit_q <= 1'b0;
                end else if (w_wr && (opn_q == OCW'(k)) && (beat_q == BCW'(CH))) begin
                    bit_q <= w_pay[OFS];
                end
            end
            assign ops[k*DATA_W + i] = bit_q;
        end
    end

    assign op          = op_q;
    assign out_valid   = valid_q;
    assign err_sync    = err_sync_q;
    assign err_overrun = err_overrun_q;

endmodule
`default_nettype wire

// File: doc/operand_deserializer.md
Name: operand_deserializer

Overview:
Parametrised input front-end for the arithmetic datapath. It reassembles a framed opcode plus NUM_OPS operands of DATA_W bits from a narrow pin bus, delivered over one or more beats. The assembled frame is presented to the compute unit with a valid/ready handshake. Resync and overrun errors are flagged because the pin side cannot be back-pressured.

Parameters:
PIN_W, 12, width of the raw input bus; payload per beat PAY_W = PIN_W-2 (PAY_W >= OP_W required)
DATA_W, 10, operand width
NUM_OPS, 2, operands per frame (>= 1)
OP_W, 4, opcode width
Derived: BEATS_PER_OP = ceil(DATA_W/PAY_W)

Ports:
clock  input  1  single system clock
reset  input  1  synchronous, active-high
io_in  input  PIN_W  beat = {payload[PAY_W-1:0], sof, vld}; bit0 = vld, bit1 = sof
ops  output  NUM_OPS*DATA_W  operand k at [k*DATA_W +: DATA_W]
op  output  OP_W  captured opcode
out_valid  output  1  frame complete, data stable
out_ready  input  1  consumer accepts frame
err_sync  output  1  one-cycle pulse: framing/resync error
err_overrun  output  1  one-cycle pulse: new frame dropped while holding

Behaviour:
- Reset (sync, same edge): state IDLE, ops=0, op=0, out_valid=0, err_sync=0, err_overrun=0, counters=0. Reset mid-frame or mid-hold discards everything; no handshake completes in the reset cycle.
- Beats with vld=0 are ignored everywhere (stall, no counter advance).
- Frame = 1 header beat (sof=1, op = payload[OP_W-1:0], upper payload ignored) + NUM_OPS*BEATS_PER_OP data beats (sof=0).
- Data beats carry operand 0 first; within an operand, least-significant chunk first. Chunk j fills bits [j*PAY_W +: PAY_W]; bits at or above DATA_W in the last chunk are discarded.
- States: IDLE, COLLECT, HOLD.
- IDLE:
  - vld&sof: capture op, clear beat/operand counters, go to COLLECT.
  - vld&!sof: beat dropped, err_sync pulses.
- COLLECT:
  - vld&!sof: write chunk, advance counters.
  - On the final data beat: go to HOLD; out_valid=1 the following cycle. Latency is 1 cycle from final beat sampled to out_valid.
  - vld&sof: resync. Capture the new op, clear counters, stay in COLLECT, err_sync pulses. Operands already written are overwritten as the new frame arrives.
- HOLD:
  - out_valid=1; ops and op are stable until the transfer completes.
  - Transfer occurs on out_valid&out_ready. Next cycle: out_valid=0, state IDLE.
  - Simultaneous transfer and vld&sof: the transfer completes and the new header is captured; next state is COLLECT with no error.
  - vld&sof with out_ready=0: header dropped, err_overrun pulses, stay in HOLD.
  - vld&!sof with out_ready=0: silently ignored. Once back in IDLE, leftover beats of a dropped frame raise err_sync per beat.
- Error pulses are exactly one cycle per offending beat; they are never sticky.
- out_valid never drops without a transfer, except on reset.

Test Plan:
- Defaults. Beats 0x00F (sof, op=3), 0x555 (a=0x155), 0xAA9 (b=0x2AA) on consecutive cycles, out_ready=1 -> out_valid high exactly 1 cycle after the 3rd beat; op=3, ops=0x2AA_155; drops the next cycle.
- Defaults, same frame with vld=0 idle cycles interleaved between beats -> identical result; out_valid 1 cycle after the last valid beat.
- Defaults, out_ready=0 while out_valid, then beat 0x01B (sof, op=6) -> err_overrun pulses 1 cycle; op stays 3 and ops stay 0x2AA_155. On releasing out_ready -> single transfer, then IDLE.
- Defaults: sof op=3, data 0x555, then sof op=9 (0x027), data 0x0051, 0x0065 -> err_sync pulses once at the second sof; final op=9, ops=0x019_014.
- PIN_W=6, DATA_W=16, NUM_OPS=1 (4 beats/op): header op=0xA, then payload nibbles 0xD, 0xC, 0xB, 0xA -> ops=0xABCD.
- Data beat 0x005 in IDLE -> err_sync pulse, no state change. Reset asserted mid-COLLECT -> all outputs 0 the next cycle; a subsequent clean frame completes normally.
